// File: rtl/bf_loop_sequencer.sv
// Instruction-level sequencer for the DekatronPC Brainfuck core.
// Steps the external IP counter, latches the ROM/Encoder opcode, hands
// arithmetic/pointer/IO opcodes to the datapath over req/ack, and resolves
// loop brackets by walking the program with a nesting-depth counter.
module bf_loop_sequencer #(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255
) (
  input  logic               CLOCK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [3:0]         OPCODE,
  input  logic               DATA_ZERO,
  input  logic               EXEC_ACK,
  output logic               IP_UP,
  output logic               IP_DOWN,
  output logic               IP_CLR,
  output logic               EXEC_REQ,
  output logic [3:0]         EXEC_OP,
  output logic [DEPTH_W-1:0] LOOP_DEPTH,
  output logic               BUSY,
  output logic               HALTED,
  output logic               ERROR
);

  // Encoder opcode map
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_RIGHT = 4'd3;
  localparam logic [3:0] OP_LEFT  = 4'd4;
  localparam logic [3:0] OP_OPEN  = 4'd5;
  localparam logic [3:0] OP_CLOSE = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE   = DEPTH_W'(1);
  localparam logic [DEPTH_W:0]   MAX_DEPTH_L = (DEPTH_W+1)'(MAX_DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_ACK,
    ST_SF_SETTLE,
    ST_SF_EVAL,
    ST_SB_SETTLE,
    ST_SB_EVAL,
    ST_HALTED,
    ST_ERROR
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         op_reg, op_next;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic               exec_req_reg, exec_req_next;
  logic [3:0]         exec_op_reg, exec_op_next;
  logic [15:0]        ip_shadow_reg;

  logic               ip_up_dec, ip_down_dec, ip_clr_dec;
  logic               ip_up_g, ip_down_g, ip_clr_g;

  logic               scan_inc, scan_dec, scan_ovf;
  logic [DEPTH_W-1:0] depth_scan;

  // One bit per opcode value: set for opcodes that go to the datapath.
  logic [15:0]        exec_mask;

  for (genvar gi = 0; gi < 16; gi++) begin : g_exec_mask
    assign exec_mask[gi] = (4'(gi) == OP_INC)  || (4'(gi) == OP_DEC)  ||
                           (4'(gi) == OP_RIGHT) || (4'(gi) == OP_LEFT) ||
                           (4'(gi) == OP_OUT)  || (4'(gi) == OP_IN);
  end

  // Depth step for the current scan cell: forward scans nest on '[',
  // backward scans nest on ']'.
  always_comb begin
    scan_inc = 1'b0;
    scan_dec = 1'b0;
    if (state_reg == ST_SB_EVAL) begin
      scan_inc = (OPCODE == OP_CLOSE);
      scan_dec = (OPCODE == OP_OPEN);
    end else begin
      scan_inc = (OPCODE == OP_OPEN);
      scan_dec = (OPCODE == OP_CLOSE);
    end
    depth_scan = depth_reg;
    if (scan_inc) begin
      depth_scan = depth_reg + DEPTH_ONE;
    end else if (scan_dec) begin
      depth_scan = depth_reg - DEPTH_ONE;
    end
    scan_ovf = scan_inc && ({1'b0, depth_reg} >= MAX_DEPTH_L);
  end

  // Next-state logic and IP pulse decode.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    depth_next    = depth_reg;
    exec_req_next = exec_req_reg;
    exec_op_next  = exec_op_reg;
    ip_up_dec     = 1'b0;
    ip_down_dec   = 1'b0;
    ip_clr_dec    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          ip_clr_dec = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        op_next    = OPCODE;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (op_reg == OP_HALT) begin
          state_next = ST_HALTED;
        end else if (exec_mask[op_reg]) begin
          exec_req_next = 1'b1;
          exec_op_next  = op_reg;
          state_next    = ST_WAIT_ACK;
        end else if ((op_reg == OP_OPEN) && DATA_ZERO) begin
          depth_next = DEPTH_ONE;
          ip_up_dec  = 1'b1;
          state_next = ST_SF_SETTLE;
        end else if ((op_reg == OP_CLOSE) && !DATA_ZERO) begin
          depth_next  = DEPTH_ONE;
          ip_down_dec = 1'b1;
          state_next  = ST_SB_SETTLE;
        end else begin
          ip_up_dec  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_WAIT_ACK: begin
        if (EXEC_ACK) begin
          exec_req_next = 1'b0;
          ip_up_dec     = 1'b1;
          state_next    = ST_FETCH;
        end
      end
      ST_SF_SETTLE: begin
        state_next = ST_SF_EVAL;
      end
      ST_SF_EVAL: begin
        if ((OPCODE == OP_HALT) || scan_ovf) begin
          depth_next = '0;
          state_next = ST_ERROR;
        end else begin
          depth_next = depth_scan;
          ip_up_dec  = 1'b1;
          state_next = (depth_scan == '0) ? ST_FETCH : ST_SF_SETTLE;
        end
      end
      ST_SB_SETTLE: begin
        state_next = ST_SB_EVAL;
      end
      ST_SB_EVAL: begin
        if ((OPCODE == OP_HALT) || scan_ovf) begin
          depth_next = '0;
          state_next = ST_ERROR;
        end else if (depth_scan == '0) begin
          depth_next = '0;
          ip_up_dec  = 1'b1;
          state_next = ST_FETCH;
        end else if (ip_shadow_reg == 16'd0) begin
          // Walking backward off the start of the program: no matching '['.
          depth_next = '0;
          state_next = ST_ERROR;
        end else begin
          depth_next  = depth_scan;
          ip_down_dec = 1'b1;
          state_next  = ST_SB_SETTLE;
        end
      end
      ST_HALTED, ST_ERROR: begin
        state_next = state_reg;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A reset edge must not also move the IP counter.
  assign ip_up_g   = ip_up_dec   & RST_N;
  assign ip_down_g = ip_down_dec & RST_N;
  assign ip_clr_g  = ip_clr_dec  & RST_N;

  // State, latched opcode, depth, request and IP shadow registers.
  always_ff @(posedge CLOCK) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      op_reg        <= 4'd0;
      depth_reg     <= '0;
      exec_req_reg  <= 1'b0;
      exec_op_reg   <= 4'd0;
      ip_shadow_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      depth_reg    <= depth_next;
      exec_req_reg <= exec_req_next;
      exec_op_reg  <= exec_op_next;
      if (ip_clr_g) begin
        ip_shadow_reg <= 16'd0;
      end else if (ip_up_g) begin
        ip_shadow_reg <= ip_shadow_reg + 16'd1;
      end else if (ip_down_g) begin
        ip_shadow_reg <= ip_shadow_reg - 16'd1;
      end
    end
  end

  assign IP_UP      = ip_up_g;
  assign IP_DOWN    = ip_down_g;
  assign IP_CLR     = ip_clr_g;
  assign EXEC_REQ   = exec_req_reg;
  assign EXEC_OP    = exec_op_reg;
  assign LOOP_DEPTH = depth_reg;
  assign BUSY       = (state_reg != ST_IDLE) && (state_reg != ST_HALTED) &&
                      (state_reg != ST_ERROR);
  assign HALTED     = (state_reg == ST_HALTED);
  assign ERROR      = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_bf_loop_sequencer.sv
// Bench for bf_loop_sequencer: models the IP counter + program ROM and a
// datapath responder; expected EXEC_OP values are queued per program and
// popped as requests appear.
module tb_bf_loop_sequencer;

  logic       CLOCK = 1'b0;
  logic       RST_N;
  logic       START;
  logic [3:0] OPCODE;
  logic       DATA_ZERO;
  logic       EXEC_ACK;
  logic       IP_UP, IP_DOWN, IP_CLR, EXEC_REQ, BUSY, HALTED, ERROR;
  logic [3:0] EXEC_OP;
  logic [7:0] LOOP_DEPTH;

  always #5 CLOCK = ~CLOCK;

  bf_loop_sequencer dut (
    .CLOCK(CLOCK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE),
    .DATA_ZERO(DATA_ZERO), .EXEC_ACK(EXEC_ACK), .IP_UP(IP_UP),
    .IP_DOWN(IP_DOWN), .IP_CLR(IP_CLR), .EXEC_REQ(EXEC_REQ),
    .EXEC_OP(EXEC_OP), .LOOP_DEPTH(LOOP_DEPTH), .BUSY(BUSY),
    .HALTED(HALTED), .ERROR(ERROR)
  );

  // External IP counter and program ROM
  logic [15:0] ip_model;
  logic [3:0]  prog [0:15];

  always @(posedge CLOCK) begin
    if (IP_CLR) ip_model <= 16'd0;
    else if (IP_UP) ip_model <= ip_model + 16'd1;
    else if (IP_DOWN) ip_model <= ip_model - 16'd1;
  end

  assign OPCODE = (ip_model < 16'd16) ? prog[ip_model[3:0]] : 4'hF;

  int checks = 0;
  int failures = 0;
  int n_up = 0, n_down = 0, n_clr = 0;
  bit prev_up = 0, rec_depth = 0, ack_tied = 0, dz_on_down = 0, dz_pending = 0;
  bit req_active = 0;
  int ack_delay = 0;
  int req_len = 0;
  logic [3:0] held_op;
  logic [3:0] exp_q[$];
  int depth_log[$];
  int req_lens[$];

  // One clock of bench activity: datapath responder + scoreboard, then pulse monitor.
  task automatic tick();
    logic [3:0] exp_op;
    @(negedge CLOCK);
    if (dz_pending) begin
      DATA_ZERO = 1'b1;
      dz_pending = 0;
    end
    if (EXEC_REQ === 1'b1) begin
      if (!req_active) begin
        req_active = 1;
        req_len = 0;
        held_op = EXEC_OP;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL exec_unexpected: got EXEC_OP=%0d, no request expected", EXEC_OP);
        end else begin
          exp_op = exp_q.pop_front();
          if (EXEC_OP !== exp_op) begin
            failures++;
            $display("FAIL exec_op: got %0d, expected %0d", EXEC_OP, exp_op);
          end
        end
      end else begin
        checks++;
        if (EXEC_OP !== held_op) begin
          failures++;
          $display("FAIL exec_op_stable: got %0d, expected %0d", EXEC_OP, held_op);
        end
      end
      req_len++;
    end else begin
      if (req_active) req_lens.push_back(req_len);
      req_active = 0;
    end
    if (ack_tied) EXEC_ACK = 1'b1;
    else EXEC_ACK = req_active && (req_len == ack_delay + 1);
    #1;
    if (rec_depth && prev_up) depth_log.push_back(int'(LOOP_DEPTH));
    checks++;
    if ($countones({IP_UP, IP_DOWN, IP_CLR}) > 1) begin
      failures++;
      $display("FAIL ip_pulse_overlap: got up=%0b down=%0b clr=%0b, expected at most one",
               IP_UP, IP_DOWN, IP_CLR);
    end
    if (IP_UP) n_up++;
    if (IP_DOWN) n_down++;
    if (IP_CLR) n_clr++;
    prev_up = IP_UP;
    if (dz_on_down && IP_DOWN) dz_pending = 1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    START = 1'b0;
    ack_tied = 0;
    ack_delay = 0;
    dz_on_down = 0;
    dz_pending = 0;
    rec_depth = 0;
    tick();
    tick();
    RST_N = 1'b1;
    exp_q.delete();
    depth_log.delete();
    req_lens.delete();
  endtask

  task automatic load_prog(input logic [63:0] words, input int n);
    for (int i = 0; i < 16; i++) prog[i] = (i < n) ? words[4*i +: 4] : 4'hF;
  endtask

  // Raise START in IDLE; IP_CLR must answer in the same cycle.
  task automatic start_run(input string name);
    START = 1'b1;
    #1;
    checks++;
    if (IP_CLR !== 1'b1) begin
      failures++;
      $display("FAIL %s_start_clr: got IP_CLR=%0b, expected 1", name, IP_CLR);
    end
    tick();
    START = 1'b0;
  endtask

  task automatic run_to_end(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!(HALTED || ERROR) && cycles < budget) begin
      tick();
      cycles++;
    end
    checks++;
    if (!(HALTED || ERROR)) begin
      failures++;
      $display("FAIL %s_timeout: got no HALTED/ERROR after %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b1;
    DATA_ZERO = 1'b0;
    EXEC_ACK = 1'b0;
    load_prog(64'hF, 1);
    #1;
    checks++;
    if (IP_CLR !== 1'b0) begin
      failures++;
      $display("FAIL reset_clr_gated: got IP_CLR=%0b, expected 0", IP_CLR);
    end
    tick();
    tick();
    checks++;
    if ({IP_UP, IP_DOWN, IP_CLR, EXEC_REQ, BUSY, HALTED, ERROR} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, expected 0000000",
               {IP_UP, IP_DOWN, IP_CLR, EXEC_REQ, BUSY, HALTED, ERROR});
    end
    checks++;
    if (EXEC_OP !== 4'd0 || LOOP_DEPTH !== 8'd0) begin
      failures++;
      $display("FAIL reset_regs: got op=%0d depth=%0d, expected 0 0", EXEC_OP, LOOP_DEPTH);
    end
    START = 1'b0;
    RST_N = 1'b1;
  endtask

  task automatic test_reset_mid_handshake();
    int cyc;
    int n;
    apply_reset();
    load_prog(64'hF1, 2);
    ack_delay = 1000;
    exp_q.push_back(4'd1);
    start_run("midrst");
    n = 0;
    while (EXEC_REQ !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    RST_N = 1'b0;
    #1;
    checks++;
    if ({IP_UP, IP_DOWN, IP_CLR} !== 3'b0) begin
      failures++;
      $display("FAIL midrst_pulses: got %b, expected 000", {IP_UP, IP_DOWN, IP_CLR});
    end
    tick();
    checks++;
    if ({EXEC_REQ, BUSY, IP_UP, IP_DOWN, IP_CLR, HALTED, ERROR} !== 7'b0) begin
      failures++;
      $display("FAIL midrst_state: got %b, expected 0000000",
               {EXEC_REQ, BUSY, IP_UP, IP_DOWN, IP_CLR, HALTED, ERROR});
    end
    RST_N = 1'b1;
    ack_delay = 0;
    exp_q.delete();
    exp_q.push_back(4'd1);
    start_run("midrst_restart");
    run_to_end("midrst", 50, cyc);
    checks++;
    if (HALTED !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_finish: got HALTED=%0b pending=%0d, expected 1 0", HALTED, exp_q.size());
    end
  endtask

  task automatic test_exec_sequence();
    int cyc;
    int up0;
    apply_reset();
    load_prog(64'hF11, 3);
    ack_tied = 1;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    up0 = n_up;
    start_run("exec");
    run_to_end("exec", 50, cyc);
    checks++;
    if (HALTED !== 1'b1 || cyc != 8) begin
      failures++;
      $display("FAIL exec_halt_cycle: got HALTED=%0b at cycle %0d, expected 1 at 8", HALTED, cyc);
    end
    checks++;
    if (n_up - up0 != 2 || req_lens.size() != 2) begin
      failures++;
      $display("FAIL exec_counts: got ip_up=%0d reqs=%0d, expected 2 2", n_up - up0, req_lens.size());
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (HALTED !== 1'b1 || BUSY !== 1'b0 || n_up - up0 != 2) begin
      failures++;
      $display("FAIL exec_halt_sticky: got HALTED=%0b BUSY=%0b ip_up=%0d, expected 1 0 2",
               HALTED, BUSY, n_up - up0);
    end
    ack_tied = 0;
  endtask

  task automatic test_forward_scan();
    int cyc;
    int down0;
    int exp_depth [6] = '{1, 1, 2, 2, 1, 0};
    apply_reset();
    load_prog(64'hF7662515, 8);
    DATA_ZERO = 1'b1;
    exp_q.push_back(4'd7);
    rec_depth = 1;
    down0 = n_down;
    start_run("fwd");
    run_to_end("fwd", 100, cyc);
    rec_depth = 0;
    checks++;
    if (depth_log.size() < 6) begin
      failures++;
      $display("FAIL fwd_depth_len: got %0d samples, expected at least 6", depth_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (depth_log[i] != exp_depth[i]) begin
          failures++;
          $display("FAIL fwd_depth[%0d]: got %0d, expected %0d", i, depth_log[i], exp_depth[i]);
        end
      end
    end
    checks++;
    if (HALTED !== 1'b1 || exp_q.size() != 0 || n_down != down0) begin
      failures++;
      $display("FAIL fwd_finish: got HALTED=%0b pending=%0d ip_down=%0d, expected 1 0 0",
               HALTED, exp_q.size(), n_down - down0);
    end
  endtask

  task automatic test_backward_scan();
    int cyc;
    int down0;
    apply_reset();
    load_prog(64'hF6251, 5);
    DATA_ZERO = 1'b0;
    dz_on_down = 1;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd2);
    down0 = n_down;
    start_run("bwd");
    run_to_end("bwd", 100, cyc);
    dz_on_down = 0;
    checks++;
    if (n_down - down0 != 2) begin
      failures++;
      $display("FAIL bwd_ip_down: got %0d, expected 2", n_down - down0);
    end
    checks++;
    if (HALTED !== 1'b1 || ERROR !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bwd_finish: got HALTED=%0b ERROR=%0b pending=%0d, expected 1 0 0",
               HALTED, ERROR, exp_q.size());
    end
  endtask

  task automatic test_scan_error();
    int cyc;
    int up0, dn0, clr0;
    apply_reset();
    load_prog(64'hF155, 4);
    DATA_ZERO = 1'b1;
    start_run("scanerr");
    run_to_end("scanerr", 100, cyc);
    checks++;
    if (ERROR !== 1'b1 || HALTED !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL scanerr_flags: got ERROR=%0b HALTED=%0b BUSY=%0b, expected 1 0 0",
               ERROR, HALTED, BUSY);
    end
    up0 = n_up; dn0 = n_down; clr0 = n_clr;
    START = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    START = 1'b0;
    checks++;
    if (n_up != up0 || n_down != dn0 || n_clr != clr0 || ERROR !== 1'b1 || EXEC_REQ !== 1'b0) begin
      failures++;
      $display("FAIL scanerr_sticky: got pulses=%0d ERROR=%0b EXEC_REQ=%0b, expected 0 1 0",
               (n_up - up0) + (n_down - dn0) + (n_clr - clr0), ERROR, EXEC_REQ);
    end
  endtask

  task automatic test_ack_delay();
    int cyc;
    int up0;
    apply_reset();
    load_prog(64'hF71, 3);
    ack_delay = 5;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd7);
    up0 = n_up;
    start_run("ackdly");
    EXEC_ACK = 1'b1;
    tick();
    run_to_end("ackdly", 100, cyc);
    tick();
    checks++;
    if (req_lens.size() != 2) begin
      failures++;
      $display("FAIL ackdly_reqs: got %0d requests, expected 2", req_lens.size());
    end else begin
      checks++;
      if (req_lens[0] != 6 || req_lens[1] != 6) begin
        failures++;
        $display("FAIL ackdly_hold: got %0d/%0d cycles, expected 6/6", req_lens[0], req_lens[1]);
      end
    end
    checks++;
    if (HALTED !== 1'b1 || n_up - up0 != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ackdly_finish: got HALTED=%0b ip_up=%0d pending=%0d, expected 1 2 0",
               HALTED, n_up - up0, exp_q.size());
    end
    ack_delay = 0;
  endtask

  task automatic test_ip_underflow();
    int cyc;
    int dn0;
    apply_reset();
    load_prog(64'hF61, 3);
    DATA_ZERO = 1'b0;
    exp_q.push_back(4'd1);
    dn0 = n_down;
    start_run("uflow");
    run_to_end("uflow", 100, cyc);
    checks++;
    if (ERROR !== 1'b1 || n_down - dn0 != 1 || LOOP_DEPTH !== 8'd0) begin
      failures++;
      $display("FAIL uflow_error: got ERROR=%0b ip_down=%0d depth=%0d, expected 1 1 0",
               ERROR, n_down - dn0, LOOP_DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_handshake();
    test_exec_sequence();
    test_forward_scan();
    test_backward_scan();
    test_scan_error();
    test_ack_delay();
    test_ip_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, expected earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
